// File: rtl/dac_seq_pkg.sv
// Shared encodings and saturating arithmetic for the SPGD DAC dither sequencer.
package dac_seq_pkg;

  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_STATIC = 2'b01;
  localparam logic [1:0] MODE_DITHER = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [1:0] PHASE_IDLE  = 2'b00;
  localparam logic [1:0] PHASE_PLUS  = 2'b01;
  localparam logic [1:0] PHASE_MINUS = 2'b10;
  localparam logic [1:0] PHASE_NOM   = 2'b11;

  typedef enum logic [1:0] {IDLE, PLUS, MINUS, NOM} state_t;

  localparam int SAT_MAX_W = 32;

  // Operands are sign-extended to SAT_MAX_W; the result is clamped to a signed
  // range of 'width' bits and returned sign-extended.
  function automatic logic signed [SAT_MAX_W:0] sat_addsub(
    input logic signed [SAT_MAX_W-1:0] a,
    input logic signed [SAT_MAX_W-1:0] b,
    input logic                        sub,
    input int                          width
  );
    logic signed [SAT_MAX_W:0] full;
    logic signed [SAT_MAX_W:0] one;
    logic signed [SAT_MAX_W:0] max_v;
    logic signed [SAT_MAX_W:0] min_v;
    one   = 1;
    full  = sub ? ({a[SAT_MAX_W-1], a} - {b[SAT_MAX_W-1], b})
                : ({a[SAT_MAX_W-1], a} + {b[SAT_MAX_W-1], b});
    max_v = (one <<< (width - 1)) - one;
    min_v = -(one <<< (width - 1));
    if (full > max_v)      return max_v;
    else if (full < min_v) return min_v;
    else                   return full;
  endfunction

endpackage

// File: rtl/dither_sat_addsub.sv
// One channel of saturating U+dU / U-dU, purely combinational.
module dither_sat_addsub
  import dac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 14
) (
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] du,
  input  logic                  sub,
  output logic [DATA_WIDTH-1:0] y
);

  logic signed [SAT_MAX_W-1:0] u_ext;
  logic signed [SAT_MAX_W-1:0] du_ext;
  logic signed [SAT_MAX_W:0]   y_full;
  logic                        unused_hi;

  always_comb begin
    u_ext  = {{(SAT_MAX_W-DATA_WIDTH){u[DATA_WIDTH-1]}}, u};
    du_ext = {{(SAT_MAX_W-DATA_WIDTH){du[DATA_WIDTH-1]}}, du};
    y_full = sat_addsub(u_ext, du_ext, sub, DATA_WIDTH);
  end

  // After clamping, the upper bits are only the sign extension of bit DATA_WIDTH-1.
  assign y         = y_full[DATA_WIDTH-1:0];
  assign unused_hi = ^y_full[SAT_MAX_W:DATA_WIDTH];

endmodule

// File: rtl/dac_dither_seq.sv
// SPGD DAC output sequencer: zero / static U / dither U+dU, U-dU, U with
// programmable settle time, registered and saturated outputs.
module dac_dither_seq
  import dac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int N_CH       = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         adc_clk,
  input  logic                         adc_rstn,
  input  logic [1:0]                   mode,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         settle_cycles,
  input  logic [N_CH*DATA_WIDTH-1:0]   u_in,
  input  logic [N_CH*DATA_WIDTH-1:0]   du_in,
  output logic [N_CH*DATA_WIDTH-1:0]   dac_out,
  output logic [1:0]                   phase,
  output logic                         sample_stb,
  output logic                         busy,
  output logic                         done
);

  localparam int VW = N_CH * DATA_WIDTH;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [VW-1:0]        u_lat_q, u_lat_d;
  logic [VW-1:0]        du_lat_q, du_lat_d;
  logic [VW-1:0]        dac_q, dac_d;
  logic [1:0]           phase_q, phase_d;
  logic                 stb_q, stb_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [VW-1:0]        op_u, op_du, addsub_y;
  logic                 op_sub;

  // The plus step is computed from live inputs on the start edge; later steps use the latches.
  assign op_u   = (state_q == IDLE) ? u_in  : u_lat_q;
  assign op_du  = (state_q == IDLE) ? du_in : du_lat_q;
  assign op_sub = (state_q == PLUS);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    dither_sat_addsub #(.DATA_WIDTH(DATA_WIDTH)) u_sat (
      .u   (op_u[k*DATA_WIDTH +: DATA_WIDTH]),
      .du  (op_du[k*DATA_WIDTH +: DATA_WIDTH]),
      .sub (op_sub),
      .y   (addsub_y[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    u_lat_d  = u_lat_q;
    du_lat_d = du_lat_q;
    dac_d    = dac_q;
    phase_d  = PHASE_IDLE;
    stb_d    = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    if (mode != MODE_DITHER) begin
      state_d = IDLE;
      cnt_d   = '0;
      u_lat_d = u_in;
      case (mode)
        MODE_ZERO:   dac_d = '0;
        MODE_STATIC: dac_d = u_in;
        default:     dac_d = dac_q;
      endcase
    end else begin
      case (state_q)
        IDLE: begin
          u_lat_d = u_in;
          dac_d   = u_in;
          if (start) begin
            state_d  = PLUS;
            du_lat_d = du_in;
            cnt_d    = settle_cycles;
            dac_d    = addsub_y;
            phase_d  = PHASE_PLUS;
            stb_d    = (settle_cycles == '0);
            busy_d   = 1'b1;
          end
        end
        PLUS, MINUS: begin
          busy_d = 1'b1;
          // The strobe is registered, so it is raised on the edge entering the count-0 cycle.
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNT_WIDTH'(1);
            stb_d   = (cnt_q == CNT_WIDTH'(1));
            phase_d = (state_q == PLUS) ? PHASE_PLUS : PHASE_MINUS;
          end else if (state_q == PLUS) begin
            state_d = MINUS;
            cnt_d   = settle_cycles;
            dac_d   = addsub_y;
            phase_d = PHASE_MINUS;
            stb_d   = (settle_cycles == '0);
          end else begin
            state_d = NOM;
            cnt_d   = '0;
            dac_d   = u_lat_q;
            phase_d = PHASE_NOM;
            done_d  = 1'b1;
          end
        end
        NOM: begin
          state_d = IDLE;
          u_lat_d = u_in;
          dac_d   = u_in;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk or negedge adc_rstn) begin
    if (!adc_rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      u_lat_q  <= '0;
      du_lat_q <= '0;
      dac_q    <= '0;
      phase_q  <= PHASE_IDLE;
      stb_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      u_lat_q  <= u_lat_d;
      du_lat_q <= du_lat_d;
      dac_q    <= dac_d;
      phase_q  <= phase_d;
      stb_q    <= stb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dac_out    = dac_q;
  assign phase      = phase_q;
  assign sample_stb = stb_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_dac_dither_seq.sv
// Directed bench for dac_dither_seq: reset, static, dither timing, saturation,
// back-to-back starts, abort, hold, input isolation and asynchronous reset.
module tb_dac_dither_seq;

  localparam int DW = 14;
  localparam int NC = 2;
  localparam int CW = 16;

  logic              adc_clk;
  logic              adc_rstn;
  logic [1:0]        mode;
  logic              start;
  logic [CW-1:0]     settle_cycles;
  logic [NC*DW-1:0]  u_in;
  logic [NC*DW-1:0]  du_in;
  logic [NC*DW-1:0]  dac_out;
  logic [1:0]        phase;
  logic              sample_stb;
  logic              busy;
  logic              done;

  int vectors;
  int miscompares;

  dac_dither_seq #(.DATA_WIDTH(DW), .N_CH(NC), .CNT_WIDTH(CW)) dut (
    .adc_clk       (adc_clk),
    .adc_rstn      (adc_rstn),
    .mode          (mode),
    .start         (start),
    .settle_cycles (settle_cycles),
    .u_in          (u_in),
    .du_in         (du_in),
    .dac_out       (dac_out),
    .phase         (phase),
    .sample_stb    (sample_stb),
    .busy          (busy),
    .done          (done)
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  task automatic applyStimulus(input logic [1:0] m, input logic st, input int settle,
                               input int u0, input int u1, input int du0, input int du1);
    mode          = m;
    start         = st;
    settle_cycles = CW'(settle);
    u_in          = {DW'(u1), DW'(u0)};
    du_in         = {DW'(du1), DW'(du0)};
  endtask

  task automatic advanceCycle();
    @(posedge adc_clk);
    @(negedge adc_clk);
  endtask

  task automatic checkOutput(input string tag, input int d0, input int d1, input logic [1:0] ph,
                             input logic stb, input logic bsy, input logic dn);
    logic [NC*DW+4:0] obs;
    logic [NC*DW+4:0] exp_v;
    obs   = {dac_out, phase, sample_stb, busy, done};
    exp_v = {DW'(d1), DW'(d0), ph, stb, bsy, dn};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed dac=%h ph=%b stb=%b busy=%b done=%b, expected %h",
             tag, obs[NC*DW+4:5], obs[4:3], obs[2], obs[1], obs[0], exp_v);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    adc_rstn    = 1'b0;
    applyStimulus(2'b01, 1'b0, 0, 100, -200, 0, 0);

    // Reset held across a clock edge
    @(negedge adc_clk);
    checkOutput("reset_hold", 0, 0, 2'b00, 0, 0, 0);
    adc_rstn = 1'b1;
    advanceCycle();
    checkOutput("static_after_reset", 100, -200, 2'b00, 0, 0, 0);

    // Dither sequence, settle=3
    $display("[TB] dither settle=3");
    applyStimulus(2'b10, 1'b0, 3, 1000, -1000, 50, 25);
    advanceCycle();
    checkOutput("dither_idle", 1000, -1000, 2'b00, 0, 0, 0);
    start = 1'b1;
    advanceCycle();
    // Inputs changed mid-sequence must not disturb the latched values
    applyStimulus(2'b10, 1'b0, 3, 0, 0, 7, 7);
    checkOutput("plus_1", 1050, -975, 2'b01, 0, 1, 0);
    for (int i = 2; i <= 4; i++) begin
      advanceCycle();
      checkOutput($sformatf("plus_%0d", i), 1050, -975, 2'b01, logic'(i == 4), 1, 0);
    end
    for (int i = 1; i <= 4; i++) begin
      advanceCycle();
      checkOutput($sformatf("minus_%0d", i), 950, -1025, 2'b10, logic'(i == 4), 1, 0);
    end
    applyStimulus(2'b10, 1'b0, 3, 1000, -1000, 50, 25);
    advanceCycle();
    checkOutput("nom_done", 1000, -1000, 2'b11, 0, 1, 1);
    advanceCycle();
    checkOutput("idle_after", 1000, -1000, 2'b00, 0, 0, 0);

    // Saturation, settle=0, back-to-back start handling
    $display("[TB] saturation settle=0");
    applyStimulus(2'b10, 1'b1, 0, 8000, -8000, 500, 500);
    advanceCycle();
    start = 1'b0;
    checkOutput("sat_plus", 8191, -7500, 2'b01, 1, 1, 0);
    advanceCycle();
    checkOutput("sat_minus", 7500, -8192, 2'b10, 1, 1, 0);
    start = 1'b1;
    advanceCycle();
    checkOutput("sat_nom", 8000, -8000, 2'b11, 0, 1, 1);
    advanceCycle();
    checkOutput("start_in_done_ignored", 8000, -8000, 2'b00, 0, 0, 0);
    advanceCycle();
    start = 1'b0;
    checkOutput("restart_plus", 8191, -7500, 2'b01, 1, 1, 0);
    advanceCycle();
    checkOutput("restart_minus", 7500, -8192, 2'b10, 1, 1, 0);
    advanceCycle();
    checkOutput("restart_nom", 8000, -8000, 2'b11, 0, 1, 1);
    advanceCycle();
    checkOutput("restart_idle", 8000, -8000, 2'b00, 0, 0, 0);

    // Abort during the minus step
    $display("[TB] abort");
    applyStimulus(2'b10, 1'b1, 3, 1000, -1000, 50, 25);
    advanceCycle();
    start = 1'b0;
    repeat (4) advanceCycle();
    checkOutput("abort_minus", 950, -1025, 2'b10, 0, 1, 0);
    mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      advanceCycle();
      checkOutput($sformatf("abort_zero_%0d", i), 0, 0, 2'b00, 0, 0, 0);
    end

    // Hold freezes outputs
    $display("[TB] hold");
    applyStimulus(2'b01, 1'b0, 0, 1234, -4321, 0, 0);
    advanceCycle();
    checkOutput("static_load", 1234, -4321, 2'b00, 0, 0, 0);
    applyStimulus(2'b11, 1'b0, 0, 5, 5, 0, 0);
    advanceCycle();
    checkOutput("hold_1", 1234, -4321, 2'b00, 0, 0, 0);
    u_in = {DW'(-3), DW'(77)};
    advanceCycle();
    checkOutput("hold_2", 1234, -4321, 2'b00, 0, 0, 0);

    // Start outside dither mode is ignored
    applyStimulus(2'b01, 1'b1, 0, 300, 400, 10, 10);
    advanceCycle();
    start = 1'b0;
    checkOutput("start_static_ignored", 300, 400, 2'b00, 0, 0, 0);

    // Asynchronous reset mid-sequence
    $display("[TB] async reset");
    applyStimulus(2'b10, 1'b1, 3, 1000, -1000, 50, 25);
    advanceCycle();
    start = 1'b0;
    advanceCycle();
    checkOutput("pre_reset_plus", 1050, -975, 2'b01, 0, 1, 0);
    #1 adc_rstn = 1'b0;
    #1 checkOutput("async_reset", 0, 0, 2'b00, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
